// File: rtl/mul_div_if.sv
// Execute-stage handshake between the core and the iterative
// multiply/divide unit: request operands in, write-back beat out.
interface mul_div_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              div_by_zero;

    modport master (
        output start, op, rs_data, rt_data, rd_addr,
        input  busy, wb_en, wb_data, wb_rd, div_by_zero
    );

    modport slave (
        input  start, op, rs_data, rt_data, rd_addr,
        output busy, wb_en, wb_data, wb_rd, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring),
// one bit per clock, single outstanding op, registered write-back.
module mul_div_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic     clk,
    input logic     rst,
    mul_div_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE,
        S_WB
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                wb_en_q, wb_en_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [ADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic                dbz_q, dbz_d;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;
    logic              take;
    logic              accept;
    logic [DATA_W-1:0] result;

    always_comb begin
        mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                + (prod_q[0] ? {1'b0, a_q} : '0);
        // Borrow bit of the trial subtraction decides restore vs keep.
        rem_sh  = {rem_q, prod_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        take    = ~rem_sub[DATA_W];

        unique case (op_q)
            2'b01:   result = prod_q[2*DATA_W-1:DATA_W];
            2'b11:   result = rem_q;
            default: result = prod_q[DATA_W-1:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        dbz_d     = dbz_q;

        // The write-back cycle ends where IDLE begins, so a request
        // arriving then is taken without a dead cycle.
        accept = bus.start
              && (state_q == S_IDLE || state_q == S_WB);

        unique case (state_q)
            S_IDLE: ;
            S_CALC: begin
                if (op_q[1]) begin
                    rem_d  = take ? rem_sub[DATA_W-1:0]
                                  : rem_sh[DATA_W-1:0];
                    prod_d = {prod_q[2*DATA_W-1:DATA_W],
                              prod_q[DATA_W-2:0], take};
                end else begin
                    prod_d = {mul_sum, prod_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wb_en_d   = 1'b1;
                wb_data_d = result;
                wb_rd_d   = rd_q;
                dbz_d     = op_q[1] && (b_q == '0);
                state_d   = S_WB;
            end
            S_WB: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d     = bus.rs_data;
            b_d     = bus.rt_data;
            op_d    = bus.op;
            rd_d    = bus.rd_addr;
            cnt_d   = '0;
            rem_d   = '0;
            prod_d  = bus.op[1] ? {{DATA_W{1'b0}}, bus.rs_data}
                                : {{DATA_W{1'b0}}, bus.rt_data};
            busy_d  = 1'b1;
            state_d = S_CALC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: latency, results,
// operand capture, start-while-busy and reset abort.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_div_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    mul_div_unit #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [3:0]  rd;
        logic [15:0] exp;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // glitch_k >= 0 raises start again (new operands) after edge E<k>.
    task automatic run_op(input vec_t v, input int glitch_k);
        int          n_wb;
        int          lat;
        logic        busy_ok;
        logic [15:0] got_d;
        logic [3:0]  got_rd;
        logic        got_z;
        logic [15:0] hold_d;

        n_wb    = 0;
        lat     = -1;
        busy_ok = 1'b1;
        got_d   = '0;
        got_rd  = '0;
        got_z   = 1'b0;
        hold_d  = '0;

        @(negedge clk);
        bus.op      = v.op;
        bus.rs_data = v.rs;
        bus.rt_data = v.rt;
        bus.rd_addr = v.rd;
        bus.start   = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.busy !== (k <= 17)) busy_ok = 1'b0;
            if (bus.wb_en === 1'b1) begin
                n_wb++;
                lat    = k;
                got_d  = bus.wb_data;
                got_rd = bus.wb_rd;
                got_z  = bus.div_by_zero;
            end
            if (k == 19) hold_d = bus.wb_data;
            bus.start = (k == glitch_k);
            if (k == 2 || k == glitch_k) begin
                bus.op      = ~v.op;
                bus.rs_data = ~v.rs;
                bus.rt_data = v.rt + 16'd3;
                bus.rd_addr = ~v.rd;
            end
        end
        bus.start = 1'b0;

        check("wb_count", n_wb, 1);
        check("latency", lat, 17);
        check("wb_data", got_d, v.exp);
        check("wb_rd", got_rd, v.rd);
        check("div_by_zero", got_z, v.dbz);
        check("busy_profile", busy_ok, 1'b1);
        check("wb_data_hold", hold_d, v.exp);
    endtask

    initial begin
        int n_wb;

        vecs[0]  = '{2'b00, 16'h0012, 16'h0034, 4'd3,  16'h03A8, 1'b0};
        vecs[1]  = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd1,  16'hFFFE, 1'b0};
        vecs[2]  = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd2,  16'h0001, 1'b0};
        vecs[3]  = '{2'b10, 16'h0064, 16'h0007, 4'd4,  16'h000E, 1'b0};
        vecs[4]  = '{2'b11, 16'h0064, 16'h0007, 4'd5,  16'h0002, 1'b0};
        vecs[5]  = '{2'b10, 16'h1234, 16'h0000, 4'd6,  16'hFFFF, 1'b1};
        vecs[6]  = '{2'b11, 16'h1234, 16'h0000, 4'd7,  16'h1234, 1'b1};
        vecs[7]  = '{2'b01, 16'h1234, 16'h5678, 4'd8,  16'h0626, 1'b0};
        vecs[8]  = '{2'b00, 16'h1234, 16'h5678, 4'd9,  16'h0060, 1'b0};
        vecs[9]  = '{2'b10, 16'h0005, 16'h0009, 4'd10, 16'h0000, 1'b0};
        vecs[10] = '{2'b11, 16'h0005, 16'h0009, 4'd11, 16'h0005, 1'b0};
        vecs[11] = '{2'b11, 16'h8000, 16'h00FF, 4'd15, 16'h0080, 1'b0};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.rd_addr = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wb_en", bus.wb_en, 1'b0);
        check("rst_wb_data", bus.wb_data, 16'h0000);
        check("rst_wb_rd", bus.wb_rd, 4'h0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], -1);
        end

        // second request while busy, and start held two cycles
        run_op(vecs[3], 4);
        run_op(vecs[0], 0);

        // abort mid-calculation
        @(negedge clk);
        bus.op      = 2'b00;
        bus.rs_data = 16'h0100;
        bus.rt_data = 16'h0100;
        bus.rd_addr = 4'd9;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_wb_en", bus.wb_en, 1'b0);
        check("abort_wb_data", bus.wb_data, 16'h0000);
        @(negedge clk);
        rst  = 1'b0;
        n_wb = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.wb_en === 1'b1) n_wb++;
        end
        check("abort_no_wb", n_wb, 0);
        run_op(vecs[4], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
